axi_burst_writer: RTL and testbench

//  Parametrised AXI3-style write master that drains a first-word-fall-through (FWFT) FIFO into DDR as INCR bursts.

---
 rtl/axi_burst_writer_pkg.sv | 21 ++
 rtl/axi_wr_addr_gen.sv | 34 +++
 rtl/axi_burst_writer.sv | 158 +++++++++++++++
 tb/tb_axi_burst_writer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_burst_writer_pkg.sv
// Shared types and AXI constants for the FIFO-to-DDR burst writer.
package axi_burst_writer_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAddr,
      StData,
      StResp
   } state_e;

   localparam logic [1:0] AxiBurstIncr = 2'b01;
   localparam logic [1:0] BrespOkay    = 2'b00;
   localparam logic [1:0] BrespExokay  = 2'b01;
   localparam logic [1:0] BrespSlverr  = 2'b10;
   localparam logic [1:0] BrespDecerr  = 2'b11;

   function automatic logic [2:0] calc_asize(input int unsigned data_width);
      return 3'($clog2(data_width / 8));
   endfunction

endpackage

// File: rtl/axi_wr_addr_gen.sv
// Burst start address register: steps one burst slot per completed burst and
// folds back to the region base at the region end.
module axi_wr_addr_gen #(
   parameter int unsigned                  ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0]        BASE_ADDR    = '0,
   parameter logic [ADDR_WIDTH-1:0]        REGION_BYTES = ADDR_WIDTH'(32'h100000),
   parameter logic [ADDR_WIDTH-1:0]        STEP_BYTES   = ADDR_WIDTH'(32'h200)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  advance,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  wrap
);

   localparam logic [ADDR_WIDTH-1:0] RegionEnd = BASE_ADDR + REGION_BYTES;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] addr_inc;

   // Sum wraps modulo 2^ADDR_WIDTH before the region-end compare.
   assign addr_inc = addr_q + STEP_BYTES;
   assign wrap     = advance && (addr_inc == RegionEnd);
   assign addr     = addr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= BASE_ADDR;
      end else if (advance) begin
         addr_q <= wrap ? BASE_ADDR : addr_inc;
      end
   end

endmodule

// File: rtl/axi_burst_writer.sv
// AXI3-style write master draining an FWFT FIFO into a circular DDR region
// as INCR bursts, one burst outstanding at a time.
module axi_burst_writer
   import axi_burst_writer_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH    = 256,
   parameter int unsigned           ADDR_WIDTH    = 32,
   parameter int unsigned           BURST_LEN     = 16,
   parameter int unsigned           CNT_WIDTH     = 9,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
   parameter logic [ADDR_WIDTH-1:0] REGION_BYTES  = ADDR_WIDTH'(32'h100000),
   parameter logic [7:0]            AXI_ID        = 8'h00,
   parameter int unsigned           FLUSH_TIMEOUT = 1024
) (
   input  logic                    i_axi_clk,
   input  logic                    i_rst,
   input  logic [DATA_WIDTH-1:0]   i_fifo_data,
   input  logic                    i_fifo_empty,
   input  logic [CNT_WIDTH-1:0]    i_fifo_count,
   output logic                    o_rd_en,
   input  logic                    i_flush,
   output logic [7:0]              o_aid,
   output logic [ADDR_WIDTH-1:0]   o_aaddr,
   output logic [7:0]              o_alen,
   output logic [2:0]              o_asize,
   output logic [1:0]              o_aburst,
   output logic [1:0]              o_alock,
   output logic                    o_atype,
   output logic                    o_avalid,
   input  logic                    i_aready,
   output logic [7:0]              o_wid,
   output logic [DATA_WIDTH-1:0]   o_wdata,
   output logic [DATA_WIDTH/8-1:0] o_wstrb,
   output logic                    o_wlast,
   output logic                    o_wvalid,
   input  logic                    i_wready,
   input  logic [7:0]              i_bid,
   input  logic [1:0]              i_bresp,
   input  logic                    i_bvalid,
   output logic                    o_bready,
   output logic                    o_busy,
   output logic                    o_burst_done,
   output logic                    o_wrap,
   output logic                    o_err
);

   localparam int unsigned BurstBytes = BURST_LEN * DATA_WIDTH / 8;

   state_e      state_q, state_d;
   logic [7:0]  alen_q, alen_d;
   logic [7:0]  beat_q, beat_d;
   logic [31:0] tmo_q, tmo_d;
   logic        err_q, err_d;

   logic [31:0] cnt_ext;
   logic        cnt_full;
   logic        cnt_partial;
   logic        tmo_expired;
   logic        unused_bid;

   assign cnt_ext     = 32'(i_fifo_count);
   assign cnt_full    = cnt_ext >= BURST_LEN;
   assign cnt_partial = (cnt_ext != 32'd0) && !cnt_full;
   assign tmo_expired = (FLUSH_TIMEOUT != 0) && (tmo_q == FLUSH_TIMEOUT - 1);
   assign unused_bid  = ^i_bid;

   always_comb begin
      state_d      = state_q;
      alen_d       = alen_q;
      beat_d       = beat_q;
      tmo_d        = '0;
      err_d        = err_q;
      o_avalid     = 1'b0;
      o_wvalid     = 1'b0;
      o_wlast      = 1'b0;
      o_bready     = 1'b0;
      o_burst_done = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cnt_full) begin
               // A pending flush is absorbed by the full burst.
               alen_d  = 8'(BURST_LEN - 1);
               state_d = StAddr;
            end else if (cnt_partial && (i_flush || tmo_expired)) begin
               alen_d  = 8'(cnt_ext - 32'd1);
               state_d = StAddr;
            end else if (cnt_partial && (FLUSH_TIMEOUT != 0)) begin
               tmo_d = tmo_q + 32'd1;
            end
         end
         StAddr: begin
            o_avalid = 1'b1;
            beat_d   = '0;
            if (i_aready) state_d = StData;
         end
         StData: begin
            o_wvalid = !i_fifo_empty;
            o_wlast  = o_wvalid && (beat_q == alen_q);
            if (o_wvalid && i_wready) begin
               if (beat_q == alen_q) state_d = StResp;
               else                  beat_d  = beat_q + 8'd1;
            end
         end
         StResp: begin
            o_bready = 1'b1;
            if (i_bvalid) begin
               o_burst_done = 1'b1;
               if (i_bresp != BrespOkay) err_d = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_axi_clk) begin
      if (i_rst) begin
         state_q <= StIdle;
         alen_q  <= '0;
         beat_q  <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         alen_q  <= alen_d;
         beat_q  <= beat_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

   axi_wr_addr_gen #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .BASE_ADDR    (BASE_ADDR),
      .REGION_BYTES (REGION_BYTES),
      .STEP_BYTES   (ADDR_WIDTH'(BurstBytes))
   ) u_addr_gen (
      .clk     (i_axi_clk),
      .rst     (i_rst),
      .advance (o_burst_done),
      .addr    (o_aaddr),
      .wrap    (o_wrap)
   );

   assign o_rd_en  = o_wvalid & i_wready;
   assign o_aid    = AXI_ID;
   assign o_wid    = AXI_ID;
   assign o_alen   = alen_q;
   assign o_asize  = calc_asize(DATA_WIDTH);
   assign o_aburst = AxiBurstIncr;
   assign o_alock  = 2'b00;
   assign o_atype  = 1'b1;
   assign o_wdata  = i_fifo_data;
   assign o_wstrb  = '1;
   assign o_busy   = state_q != StIdle;
   assign o_err    = err_q;

endmodule

// File: tb/tb_axi_burst_writer.sv
// Directed bench for axi_burst_writer: FIFO and AXI slave models, per-burst monitor.
module tb_axi_burst_writer;

   localparam int unsigned DW = 256;
   localparam int unsigned AW = 32;
   localparam int unsigned BL = 16;
   localparam int unsigned CW = 9;

   logic          clk;
   logic          i_rst;
   logic [DW-1:0] i_fifo_data;
   logic          i_fifo_empty;
   logic [CW-1:0] i_fifo_count;
   logic          o_rd_en;
   logic          i_flush;
   logic [7:0]    o_aid;
   logic [AW-1:0] o_aaddr;
   logic [7:0]    o_alen;
   logic [2:0]    o_asize;
   logic [1:0]    o_aburst;
   logic [1:0]    o_alock;
   logic          o_atype;
   logic          o_avalid;
   logic          i_aready;
   logic [7:0]    o_wid;
   logic [DW-1:0] o_wdata;
   logic [DW/8-1:0] o_wstrb;
   logic          o_wlast;
   logic          o_wvalid;
   logic          i_wready;
   logic [7:0]    i_bid;
   logic [1:0]    i_bresp;
   logic          i_bvalid;
   logic          o_bready;
   logic          o_busy;
   logic          o_burst_done;
   logic          o_wrap;
   logic          o_err;

   axi_burst_writer #(
      .DATA_WIDTH    (DW),
      .ADDR_WIDTH    (AW),
      .BURST_LEN     (BL),
      .CNT_WIDTH     (CW),
      .BASE_ADDR     (32'h0),
      .REGION_BYTES  (32'h400),
      .AXI_ID        (8'h3C),
      .FLUSH_TIMEOUT (8)
   ) dut (
      .i_axi_clk    (clk),
      .i_rst        (i_rst),
      .i_fifo_data  (i_fifo_data),
      .i_fifo_empty (i_fifo_empty),
      .i_fifo_count (i_fifo_count),
      .o_rd_en      (o_rd_en),
      .i_flush      (i_flush),
      .o_aid        (o_aid),
      .o_aaddr      (o_aaddr),
      .o_alen       (o_alen),
      .o_asize      (o_asize),
      .o_aburst     (o_aburst),
      .o_alock      (o_alock),
      .o_atype      (o_atype),
      .o_avalid     (o_avalid),
      .i_aready     (i_aready),
      .o_wid        (o_wid),
      .o_wdata      (o_wdata),
      .o_wstrb      (o_wstrb),
      .o_wlast      (o_wlast),
      .o_wvalid     (o_wvalid),
      .i_wready     (i_wready),
      .i_bid        (i_bid),
      .i_bresp      (i_bresp),
      .i_bvalid     (i_bvalid),
      .o_bready     (o_bready),
      .o_busy       (o_busy),
      .o_burst_done (o_burst_done),
      .o_wrap       (o_wrap),
      .o_err        (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   int vectors, miscompares;
   int aw_cnt, beats, wlast_idx, data_err, stable_err, done_cnt, wrap_cnt, stray_wrap;
   logic [AW-1:0] aw_addr, prev_addr;
   logic [7:0]    aw_len, prev_len;
   logic          prev_av, stall, bubble;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_fifo();
      i_fifo_count = CW'(fifo_q.size());
      i_fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
      i_fifo_empty = (fifo_q.size() == 0) || bubble;
   endtask

   task automatic clear_mon();
      aw_cnt = 0; beats = 0; wlast_idx = -1; data_err = 0; stable_err = 0;
      done_cnt = 0; wrap_cnt = 0; stray_wrap = 0; prev_av = 1'b0;
   endtask

   task automatic load(input int n, input int tag);
      logic [DW-1:0] w;
      for (int i = 0; i < n; i++) begin
         w = {8{32'(tag + i)}};
         fifo_q.push_back(w);
         exp_q.push_back(w);
      end
      drive_fifo();
   endtask

   // One clock: observe at negedge, let the edge happen, then update models and inputs.
   task automatic tick();
      logic rd, br;
      @(negedge clk);
      rd = o_rd_en;
      br = o_bready;
      if (o_avalid && prev_av && ((o_aaddr !== prev_addr) || (o_alen !== prev_len) ||
                                  (o_asize !== 3'd5)))
         stable_err++;
      prev_av = o_avalid; prev_addr = o_aaddr; prev_len = o_alen;
      if (o_avalid && i_aready) begin
         aw_cnt++; aw_addr = o_aaddr; aw_len = o_alen;
      end
      if (rd) begin
         if (exp_q.size() == 0) data_err++;
         else begin
            if (o_wdata !== exp_q[0]) data_err++;
            void'(exp_q.pop_front());
         end
         if (o_wlast) wlast_idx = beats;
         beats++;
      end
      if (o_burst_done) begin
         done_cnt++;
         if (o_wrap) wrap_cnt++;
      end else if (o_wrap) stray_wrap++;
      @(posedge clk);
      #1;
      if (rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (i_bvalid && br) i_bvalid = 1'b0;
      else if (br)        i_bvalid = 1'b1;
      if (stall) begin
         i_wready = 1'($urandom_range(0, 1));
         i_aready = 1'($urandom_range(0, 1));
         bubble   = ($urandom_range(0, 3) == 0);
      end
      drive_fifo();
   endtask

   task automatic run_burst();
      int n;
      n = 0;
      while (done_cnt == 0 && n < 400) begin
         tick();
         n++;
      end
      if (done_cnt == 0) check("burst_timeout", 32'(done_cnt), 32'd1);
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      i_rst = 1'b1; i_flush = 1'b0; i_aready = 1'b1; i_wready = 1'b1;
      i_bid = 8'h0; i_bresp = 2'b00; i_bvalid = 1'b0; stall = 1'b0; bubble = 1'b0;
      drive_fifo();
      clear_mon();
      repeat (3) tick();
      i_rst = 1'b0;

      // Reset state and constant AW/W fields
      check("rst_avalid", 32'(o_avalid), 32'd0);
      check("rst_wvalid", 32'(o_wvalid), 32'd0);
      check("rst_wlast", 32'(o_wlast), 32'd0);
      check("rst_bready", 32'(o_bready), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_burst_done), 32'd0);
      check("rst_wrap", 32'(o_wrap), 32'd0);
      check("rst_err", 32'(o_err), 32'd0);
      check("rst_aaddr", o_aaddr, 32'h0);
      check("rst_alen", 32'(o_alen), 32'd0);
      check("aid", 32'(o_aid), 32'h3C);
      check("wid", 32'(o_wid), 32'h3C);
      check("asize", 32'(o_asize), 32'd5);
      check("aburst", 32'(o_aburst), 32'd1);
      check("alock", 32'(o_alock), 32'd0);
      check("atype", 32'(o_atype), 32'd1);
      check("wstrb", o_wstrb, 32'hFFFF_FFFF);

      // Flush with an empty FIFO is dropped
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      tick();
      check("flush_empty_busy", 32'(o_busy), 32'd0);

      // 1: full burst at base
      clear_mon();
      load(16, 32'h100);
      run_burst();
      check("t1_aw_cnt", 32'(aw_cnt), 32'd1);
      check("t1_aw_addr", aw_addr, 32'h0);
      check("t1_aw_len", 32'(aw_len), 32'd15);
      check("t1_beats", 32'(beats), 32'd16);
      check("t1_wlast_idx", 32'(wlast_idx), 32'd15);
      check("t1_data", 32'(data_err), 32'd0);
      check("t1_next_addr", o_aaddr, 32'h200);
      check("t1_wrap", 32'(wrap_cnt + stray_wrap), 32'd0);
      check("t1_idle", 32'(o_busy), 32'd0);

      // 2: flushed partial burst in the last slot; address wraps to base
      clear_mon();
      load(5, 32'h200);
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      run_burst();
      check("t2_aw_addr", aw_addr, 32'h200);
      check("t2_aw_len", 32'(aw_len), 32'd4);
      check("t2_beats", 32'(beats), 32'd5);
      check("t2_wlast_idx", 32'(wlast_idx), 32'd4);
      check("t2_data", 32'(data_err), 32'd0);
      check("t2_wrap_with_done", 32'(wrap_cnt), 32'd1);
      check("t2_stray_wrap", 32'(stray_wrap), 32'd0);
      check("t2_next_addr", o_aaddr, 32'h0);

      // 3: idle timeout forces a partial burst 8 cycles after count settles
      clear_mon();
      load(3, 32'h300);
      repeat (7) tick();
      check("t3_avalid_early", 32'(o_avalid), 32'd0);
      tick();
      check("t3_avalid_on_time", 32'(o_avalid), 32'd1);
      check("t3_alen", 32'(o_alen), 32'd2);
      run_burst();
      check("t3_aw_addr", aw_addr, 32'h0);
      check("t3_beats", 32'(beats), 32'd3);
      check("t3_wlast_idx", 32'(wlast_idx), 32'd2);
      check("t3_next_addr", o_aaddr, 32'h200);

      // 4: random AW/W stalls and FIFO bubbles
      clear_mon();
      stall = 1'b1;
      load(16, 32'h400);
      run_burst();
      stall = 1'b0; i_aready = 1'b1; i_wready = 1'b1; bubble = 1'b0;
      drive_fifo();
      check("t4_aw_cnt", 32'(aw_cnt), 32'd1);
      check("t4_aw_addr", aw_addr, 32'h200);
      check("t4_aw_len", 32'(aw_len), 32'd15);
      check("t4_aw_stable", 32'(stable_err), 32'd0);
      check("t4_rd_pulses", 32'(beats), 32'd16);
      check("t4_wlast_idx", 32'(wlast_idx), 32'd15);
      check("t4_data", 32'(data_err), 32'd0);
      check("t4_wrap", 32'(wrap_cnt), 32'd1);
      check("t4_next_addr", o_aaddr, 32'h0);

      // 6a: SLVERR sets the sticky error
      clear_mon();
      i_bresp = 2'b10;
      load(16, 32'h500);
      run_burst();
      i_bresp = 2'b00;
      check("t6_err_set", 32'(o_err), 32'd1);
      check("t6_next_addr", o_aaddr, 32'h200);

      // 6b: an OKAY burst leaves the error set
      clear_mon();
      load(3, 32'h600);
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      run_burst();
      check("t6_err_sticky", 32'(o_err), 32'd1);
      check("t6_partial_len", 32'(aw_len), 32'd2);
      check("t6_wrap_addr", o_aaddr, 32'h0);

      clear_mon();
      load(2, 32'h680);
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      run_burst();
      check("t6_pre_rst_addr", o_aaddr, 32'h200);

      // 6c: reset in the middle of DATA
      clear_mon();
      i_wready = 1'b0;
      load(16, 32'h700);
      repeat (3) tick();
      check("t6_in_data", 32'(o_wvalid), 32'd1);
      i_rst = 1'b1;
      tick();
      check("t6_rst_avalid", 32'(o_avalid), 32'd0);
      check("t6_rst_wvalid", 32'(o_wvalid), 32'd0);
      check("t6_rst_bready", 32'(o_bready), 32'd0);
      check("t6_rst_busy", 32'(o_busy), 32'd0);
      check("t6_rst_aaddr", o_aaddr, 32'h0);
      check("t6_rst_err", 32'(o_err), 32'd0);
      i_rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
